// File: rtl/sched_pkg.sv
// Shared types and constants for the two-job scheduler monitor.
package sched_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RUN0    = 2'd2,
    RUN1    = 2'd3
  } job_state_e;

endpackage

// File: rtl/sched_job.sv
// Per-job tracker: release, dispatch grant, execution countdown and deadline age.
//   state   | meaning
//   IDLE    | not released, free to start
//   PENDING | released, waiting for a processor
//   RUN0    | executing on processor 0
//   RUN1    | executing on processor 1
module sched_job
  import sched_pkg::*;
#(
  parameter int EXEC     = 3,
  parameter int DEADLINE = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic       grant0,
  input  logic       grant1,
  output job_state_e state,
  output logic       pending,
  output logic       violation
);

  localparam logic [CNT_W-1:0] EXEC_C = CNT_W'(EXEC);
  localparam logic [CNT_W-1:0] DL_C   = CNT_W'(DEADLINE);

  logic [CNT_W-1:0] age, rem, age_inc;
  logic release_ok, active, running, ticked, done;

  always_comb begin
    release_ok = start && (state == IDLE);
    active     = (state != IDLE);
    running    = (state == RUN0) || (state == RUN1);
    // The release cycle's tick never counts: state is still IDLE then.
    ticked     = tick && active;
    done       = ticked && running && (rem == CNT_W'(1));
    age_inc    = (age == CNT_MAX) ? age : age + CNT_W'(1);
    pending    = release_ok || (state == PENDING);
    violation  = (start && active) || (ticked && (age_inc == DL_C) && !done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      age   <= '0;
      rem   <= '0;
    end else begin
      if (release_ok) begin
        age <= '0;
        rem <= EXEC_C;
      end else if (ticked) begin
        age <= age_inc;
        if (running) rem <= rem - CNT_W'(1);
      end
      // Grants only arrive while pending, so they never collide with done.
      if (grant0)          state <= RUN0;
      else if (grant1)     state <= RUN1;
      else if (release_ok) state <= PENDING;
      else if (done)       state <= IDLE;
    end
  end

endmodule

// File: rtl/sched.sv
// Two-processor scheduler monitor: priority dispatch of jobs A/B, sticky error, event mirrors.
module sched
  import sched_pkg::*;
#(
  parameter int EXEC_A     = 3,
  parameter int EXEC_B     = 4,
  parameter int DEADLINE_A = 5,
  parameter int DEADLINE_B = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic sched0,
  input  logic sched1,
  input  logic startA,
  input  logic startB,
  input  logic tick,
  output logic error,
  output logic _rt_startA,
  output logic _rt_startB,
  output logic _rt_tick
);

  job_state_e state_a, state_b;
  logic pend_a, pend_b, viol_a, viol_b;
  logic busy0, busy1, busy_err;
  logic grant0_a, grant0_b, grant1_a, grant1_b;

  always_comb begin
    busy0    = (state_a == RUN0) || (state_b == RUN0);
    busy1    = (state_a == RUN1) || (state_b == RUN1);
    busy_err = (sched0 && busy0) || (sched1 && busy1);
    grant0_a = sched0 && !busy0 && pend_a;
    grant0_b = sched0 && !busy0 && !pend_a && pend_b;
    // Processor 1 takes the best pending job that processor 0 did not grab.
    grant1_a = sched1 && !busy1 && pend_a && !grant0_a;
    grant1_b = sched1 && !busy1 && pend_b && !grant0_b && !(pend_a && !grant0_a);
  end

  sched_job #(.EXEC(EXEC_A), .DEADLINE(DEADLINE_A)) u_job_a (
    .clk(clk), .rst(rst), .start(startA), .tick(tick),
    .grant0(grant0_a), .grant1(grant1_a),
    .state(state_a), .pending(pend_a), .violation(viol_a)
  );

  sched_job #(.EXEC(EXEC_B), .DEADLINE(DEADLINE_B)) u_job_b (
    .clk(clk), .rst(rst), .start(startB), .tick(tick),
    .grant0(grant0_b), .grant1(grant1_b),
    .state(state_b), .pending(pend_b), .violation(viol_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      error      <= 1'b0;
      _rt_startA <= 1'b0;
      _rt_startB <= 1'b0;
      _rt_tick   <= 1'b0;
    end else begin
      error      <= error || viol_a || viol_b || busy_err;
      _rt_startA <= startA;
      _rt_startB <= startB;
      _rt_tick   <= tick;
    end
  end

endmodule

// File: tb/tb_sched.sv
// Scoreboard bench for sched: reference model pushes expectations, a monitor pops and compares.
module tb_sched;
  import sched_pkg::*;

  logic clk = 1'b0;
  logic rst, sched0, sched1, startA, startB, tick;
  logic error, _rt_startA, _rt_startB, _rt_tick;

  sched dut (
    .clk(clk), .rst(rst), .sched0(sched0), .sched1(sched1),
    .startA(startA), .startB(startB), .tick(tick),
    .error(error), ._rt_startA(_rt_startA), ._rt_startB(_rt_startB), ._rt_tick(_rt_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       err, rta, rtb, rtt;
    job_state_e sa, sb;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, edges = 0;

  // Reference model: jobs indexed 0=A, 1=B; st 0=idle 1=pending 2=running.
  int exec_t[2] = '{3, 4};
  int dl_t[2]   = '{5, 6};
  int m_st[2], m_proc[2], m_age[2], m_rem[2], owner[2];
  bit m_err;

  function automatic job_state_e mstate(int j);
    if (m_st[j] == 0) return IDLE;
    if (m_st[j] == 1) return PENDING;
    return (m_proc[j] == 0) ? RUN0 : RUN1;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edges, act, expv);
    end
  endtask

  task automatic model_step(input bit r, input bit s0, input bit s1,
                            input bit a, input bit b, input bit t);
    bit st_in[2], sc[2], rel[2], fin[2];
    st_in[0] = a; st_in[1] = b; sc[0] = s0; sc[1] = s1;
    if (r) begin
      for (int j = 0; j < 2; j++) begin
        m_st[j] = 0; m_age[j] = 0; m_rem[j] = 0; m_proc[j] = 0; owner[j] = -1;
      end
      m_err = 0;
      return;
    end
    for (int j = 0; j < 2; j++) begin
      rel[j] = 0; fin[j] = 0;
      if (st_in[j]) begin
        if (m_st[j] == 0) begin
          m_st[j] = 1; m_age[j] = 0; m_rem[j] = exec_t[j]; rel[j] = 1;
        end else m_err = 1;
      end
    end
    if (t) begin
      for (int j = 0; j < 2; j++) begin
        if (!rel[j] && m_st[j] != 0) begin
          if (m_age[j] < 15) m_age[j]++;
          if (m_st[j] == 2) begin
            m_rem[j]--;
            if (m_rem[j] == 0) fin[j] = 1;
          end
          if (m_age[j] == dl_t[j] && !fin[j]) m_err = 1;
        end
      end
    end
    for (int j = 0; j < 2; j++) if (fin[j]) m_st[j] = 0;
    for (int p = 0; p < 2; p++) begin
      if (sc[p]) begin
        if (owner[p] != -1) m_err = 1;
        else if (m_st[0] == 1) begin m_st[0] = 2; m_proc[0] = p; owner[p] = 0; end
        else if (m_st[1] == 1) begin m_st[1] = 2; m_proc[1] = p; owner[p] = 1; end
      end
    end
    // Completed jobs release their processor only after this cycle's dispatch.
    for (int j = 0; j < 2; j++) if (fin[j]) owner[m_proc[j]] = -1;
  endtask

  task automatic step(input bit r, input bit s0, input bit s1,
                      input bit a, input bit b, input bit t);
    exp_t e;
    rst = r; sched0 = s0; sched1 = s1; startA = a; startB = b; tick = t;
    model_step(r, s0, s1, a, b, t);
    e.due = edges + 1;
    e.err = m_err;
    e.rta = r ? 1'b0 : a;
    e.rtb = r ? 1'b0 : b;
    e.rtt = r ? 1'b0 : t;
    e.sa  = mstate(0);
    e.sb  = mstate(1);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      edges++;
      #3;
      while (q.size() > 0 && q[0].due <= edges) begin
        e = q.pop_front();
        chk("error", error, e.err);
        chk("rt_startA", _rt_startA, e.rta);
        chk("rt_startB", _rt_startB, e.rtb);
        chk("rt_tick", _rt_tick, e.rtt);
        chk("state_a", dut.state_a, e.sa);
        chk("state_b", dut.state_b, e.sb);
      end
    end
  end

  initial begin : driver
    rst = 1; sched0 = 0; sched1 = 0; startA = 0; startB = 0; tick = 0;
    #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);

    // Reset mid-run after a double release of A.
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("double_start_err", error, 1'b1);
    step(1, 1, 1, 1, 1, 1);
    chk("reset_clears_err", error, 1'b0);

    // Nominal sequence, tick held high.
    for (int c = 1; c <= 11; c++) begin
      case (c)
        1:       step(0, 1, 0, 1, 0, 1);
        5:       step(0, 1, 0, 0, 1, 1);
        6:       step(0, 0, 1, 1, 0, 1);
        default: step(0, 0, 0, 0, 0, 1);
      endcase
      if (c == 4) chk("nominal_a_done", dut.state_a, IDLE);
    end
    chk("nominal_no_err", error, 1'b0);

    // Deadline miss of a never-dispatched A.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 0, 0, 0, 1);
      if (k == 4) chk("deadline_before", error, 1'b0);
      if (k == 5) chk("deadline_hit", error, 1'b1);
    end

    // Dispatch to a busy processor.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 0, 1, 1);
    chk("busy_err", error, 1'b1);
    step(0, 0, 0, 0, 0, 1);

    // Simultaneous release and dual dispatch.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("prio_a_p0", dut.state_a, RUN0);
    chk("prio_b_p1", dut.state_b, RUN1);
    repeat (6) step(0, 0, 0, 0, 0, 1);
    chk("prio_no_err", error, 1'b0);

    // No-op dispatch, then a long tickless wait with A pending.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0);
    chk("no_tick_no_err", error, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 24) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
